// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU responder and its test environment.
// Holds the opcode, status and frame-type enums, the FSM state types, the
// error-bit indices of the error response, and the two CRC helpers used to
// protect the request command and the OK response command.
package alu_pkg;

  localparam int FRAME_BITS = 11;  // start, type, payload[7:0], stop

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_OK,
    ST_ERR_DATA,
    ST_ERR_CRC,
    ST_ERR_OP
  } status_t;

  typedef enum logic {
    FT_DATA = 1'b0,
    FT_CMD  = 1'b1
  } frame_type_t;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

  // Bit positions inside one 3-bit half of the error field; the 6-bit field
  // is the same half repeated twice.
  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  // CRC-4, poly x^4+x+1, init 0, data consumed MSB first.
  function automatic logic [3:0] get_CRC4_d68(input logic [67:0] d);
    logic [3:0] crc;
    logic       fb;
    crc = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb  = crc[3] ^ d[i];
      crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return crc;
  endfunction

  // CRC-3, poly x^3+x+1, init 0, data consumed MSB first.
  function automatic logic [2:0] get_CRC3_d37(input logic [36:0] d);
    logic [2:0] crc;
    logic       fb;
    crc = 3'h0;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ d[i];
      crc = {crc[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// 11-bit frame deserialiser.
// Waits in RX_IDLE for a low start bit, then shifts type + payload (9 bits,
// MSB first) and samples the stop bit. On the stop-bit edge it pulses
// o_valid for one clock; o_type/o_payload/o_stop_err stay stable until the
// next frame starts shifting. Returns to RX_IDLE on the stop-bit edge so a
// following start bit on the very next clock is accepted.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_sin         serial line, idle high
//   o_valid       one-clock pulse after a complete frame
//   o_type        frame type bit
//   o_payload     8-bit payload
//   o_stop_err    stop bit of that frame was 0
//   o_state       current FSM state (debug)
module alu_frame_rx
  import alu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sin,
  output logic        o_valid,
  output frame_type_t o_type,
  output logic [7:0]  o_payload,
  output logic        o_stop_err,
  output rx_state_t   o_state
);

  // Bit counter value at which the stop bit is on the line.
  localparam logic [3:0] STOP_IDX = 4'd9;

  rx_state_t  r_state;
  rx_state_t  w_state_nxt;
  logic [3:0] r_bit_cnt;
  logic [8:0] r_shift;
  logic       r_valid;
  logic       r_stop_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:  if (!i_sin) w_state_nxt = RX_SHIFT;
      RX_SHIFT: if (r_bit_cnt == STOP_IDX) w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= RX_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_valid    <= 1'b0;
      r_stop_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      if (r_state == RX_SHIFT) begin
        if (r_bit_cnt == STOP_IDX) begin
          r_valid    <= 1'b1;
          r_stop_err <= ~i_sin;
          r_bit_cnt  <= '0;
        end else begin
          r_shift   <= {r_shift[7:0], i_sin};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_type     = frame_type_t'(r_shift[8]);
  assign o_payload  = r_shift[7:0];
  assign o_stop_err = r_stop_err;
  assign o_state    = r_state;

endmodule

// File: rtl/alu_serial_responder.sv
// Serial ALU responder.
// Collects DATA frames (B then A, MSB byte first) into a 64-bit buffer,
// evaluates on the CMD frame, and answers on sout with either RES_FRAMES
// DATA frames of C plus a CMD status frame, or a single CMD error frame.
// Handshake: there is no back-pressure. A CMD frame whose stop bit is
// sampled at edge N is evaluated at edge N+1 (r_eval high for one clock)
// and the response start bit appears on sout after edge N+2. The peer must
// not complete a new request while a response is still being sent.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   sin       request line, idle high, 1 bit/clk
//   sout      response line, idle high, 1 bit/clk
//   busy      high from the first start bit of a request until the last
//             stop bit of its response
module alu_serial_responder
  import alu_pkg::*;
#(
  parameter int DATA_FRAMES = 8,  // B and A are 32 bits each, so this stays 8
  parameter int RES_FRAMES  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sin,
  output logic sout,
  output logic busy
);

  localparam logic [3:0] CNT_FULL = 4'(DATA_FRAMES);
  localparam logic [3:0] CNT_SAT  = 4'(DATA_FRAMES + 1);
  localparam logic [2:0] LAST_OK  = 3'(RES_FRAMES);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  // Receive side
  logic        w_rx_valid;
  frame_type_t w_rx_type;
  logic [7:0]  w_rx_payload;
  logic        w_rx_stop_err;
  rx_state_t   w_rx_state;

  alu_frame_rx u_rx (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sin      (sin),
    .o_valid    (w_rx_valid),
    .o_type     (w_rx_type),
    .o_payload  (w_rx_payload),
    .o_stop_err (w_rx_stop_err),
    .o_state    (w_rx_state)
  );

  // Request assembly
  logic [63:0] r_buf;
  logic [3:0]  r_cnt;     // saturates one above DATA_FRAMES
  logic        r_poison;  // a frame of this request had a bad stop bit

  // Evaluation (combinational, only consumed on a CMD valid pulse)
  logic [31:0] w_b;
  logic [31:0] w_a;
  logic [2:0]  w_op;
  logic        w_crc_ok;
  logic        w_op_ok;
  logic        w_err_data;
  logic [32:0] w_res33;
  logic        w_ovf;
  logic [3:0]  w_flags;
  status_t     w_status;
  logic [2:0]  w_err3;
  logic [5:0]  w_err6;
  logic [7:0]  w_err_cmd;
  logic [7:0]  w_ok_cmd;
  logic        w_unused_bit;

  assign w_b          = r_buf[63:32];
  assign w_a          = r_buf[31:0];
  assign w_op         = w_rx_payload[6:4];
  assign w_crc_ok     = (get_CRC4_d68({w_b, w_a, 1'b1, w_op}) == w_rx_payload[3:0]);
  // A bad stop on the CMD frame itself also poisons the request.
  assign w_err_data   = r_poison | w_rx_stop_err | (r_cnt != CNT_FULL);
  assign w_unused_bit = w_rx_payload[7];

  always_comb begin
    w_res33 = '0;
    w_ovf   = 1'b0;
    w_op_ok = 1'b1;
    case (w_op)
      OP_AND: w_res33 = {1'b0, w_b & w_a};
      OP_OR:  w_res33 = {1'b0, w_b | w_a};
      OP_ADD: begin
        w_res33 = {1'b0, w_b} + {1'b0, w_a};
        w_ovf   = (w_a[31] == w_b[31]) && (w_res33[31] != w_a[31]);
      end
      OP_SUB: begin
        // bit 32 of the 33-bit difference is the borrow
        w_res33 = {1'b0, w_b} - {1'b0, w_a};
        w_ovf   = (w_b[31] != w_a[31]) && (w_res33[31] != w_b[31]);
      end
      default: w_op_ok = 1'b0;
    endcase
  end

  assign w_flags  = {w_res33[32], w_ovf, (w_res33[31:0] == 32'd0), w_res33[31]};
  assign w_ok_cmd = {1'b0, w_flags, get_CRC3_d37({w_res33[31:0], 1'b0, w_flags})};

  always_comb begin
    w_status = ST_OK;
    if (w_err_data)     w_status = ST_ERR_DATA;
    else if (!w_crc_ok) w_status = ST_ERR_CRC;
    else if (!w_op_ok)  w_status = ST_ERR_OP;
  end

  always_comb begin
    w_err3 = '0;
    case (w_status)
      ST_ERR_DATA: w_err3[ERR_DATA] = 1'b1;
      ST_ERR_CRC:  w_err3[ERR_CRC]  = 1'b1;
      ST_ERR_OP:   w_err3[ERR_OP]   = 1'b1;
      default:     w_err3 = '0;
    endcase
  end

  assign w_err6    = {w_err3, w_err3};
  assign w_err_cmd = {1'b1, w_err6, ^{1'b1, w_err6}};

  // Response registers, latched in the EVAL clock
  logic        r_eval;
  logic        r_is_err;
  logic [31:0] r_res_c;
  logic [7:0]  r_res_cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf     <= '0;
      r_cnt     <= '0;
      r_poison  <= 1'b0;
      r_eval    <= 1'b0;
      r_is_err  <= 1'b0;
      r_res_c   <= '0;
      r_res_cmd <= '0;
    end else begin
      r_eval <= 1'b0;
      if (w_rx_valid) begin
        if (w_rx_type == FT_DATA) begin
          r_buf <= {r_buf[55:0], w_rx_payload};
          if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 4'd1;
          if (w_rx_stop_err) r_poison <= 1'b1;
        end else begin
          r_eval    <= 1'b1;
          r_is_err  <= (w_status != ST_OK);
          r_res_c   <= w_res33[31:0];
          r_res_cmd <= (w_status != ST_OK) ? w_err_cmd : w_ok_cmd;
          r_buf     <= '0;
          r_cnt     <= '0;
          r_poison  <= 1'b0;
        end
      end
    end
  end

  // Transmit side
  tx_state_t   r_tx_state;
  tx_state_t   w_tx_state_nxt;
  logic [2:0]  r_frame_idx;
  logic [2:0]  w_frame_idx_nxt;
  logic [3:0]  r_bit_idx;
  logic [3:0]  w_bit_idx_nxt;
  logic [2:0]  w_last_frame;
  logic [31:0] w_c_shift;
  frame_type_t w_tx_type;
  logic [7:0]  w_tx_payload;
  logic [10:0] w_tx_frame;

  assign w_last_frame = r_is_err ? 3'd0 : LAST_OK;

  always_comb begin
    w_tx_state_nxt  = r_tx_state;
    w_frame_idx_nxt = r_frame_idx;
    w_bit_idx_nxt   = r_bit_idx;
    if (r_eval) begin
      // A fresh result always restarts the response from its first frame.
      w_tx_state_nxt  = TX_SEND;
      w_frame_idx_nxt = '0;
      w_bit_idx_nxt   = '0;
    end else if (r_tx_state == TX_SEND) begin
      if (r_bit_idx == LAST_BIT) begin
        w_bit_idx_nxt = '0;
        if (r_frame_idx == w_last_frame) begin
          w_tx_state_nxt  = TX_IDLE;
          w_frame_idx_nxt = '0;
        end else begin
          w_frame_idx_nxt = r_frame_idx + 3'd1;
        end
      end else begin
        w_bit_idx_nxt = r_bit_idx + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state  <= TX_IDLE;
      r_frame_idx <= '0;
      r_bit_idx   <= '0;
    end else begin
      r_tx_state  <= w_tx_state_nxt;
      r_frame_idx <= w_frame_idx_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
    end
  end

  always_comb begin
    // Left-shifting by whole bytes puts the byte of the current frame on top.
    w_c_shift = r_res_c << {r_frame_idx, 3'b000};
    if (!r_is_err && (r_frame_idx < LAST_OK)) begin
      w_tx_type    = FT_DATA;
      w_tx_payload = w_c_shift[31:24];
    end else begin
      w_tx_type    = FT_CMD;
      w_tx_payload = r_res_cmd;
    end
    w_tx_frame = {1'b0, w_tx_type, w_tx_payload, 1'b1};
  end

  assign sout = (r_tx_state == TX_SEND) ? w_tx_frame[LAST_BIT - r_bit_idx] : 1'b1;

  assign busy = (w_rx_state != RX_IDLE) | w_rx_valid | (r_cnt != 4'd0) | r_poison |
                r_eval | (r_tx_state != TX_IDLE);

  // Requests are far longer than responses, so an evaluation can only
  // collide with an ongoing response if the peer breaks the protocol.
  a_no_eval_during_tx: assert property (@(posedge clk) disable iff (rst)
    !(r_eval && (r_tx_state == TX_SEND)));

endmodule
